// File: rtl/goldschmidt_pkg.sv
// Shared types and constants for the Goldschmidt divider.
package goldschmidt_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_N = 2'd1,
        MUL_D = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Legal range of the iteration count.
    localparam int ITERS_MIN = 1;
    localparam int ITERS_MAX = 8;

    // Counter wide enough to hold ITERS_MAX.
    localparam int CNT_W = $clog2(ITERS_MAX + 1);

endpackage

// File: rtl/goldschmidt_div_if.sv
// Request/response bundle between a requester and the Goldschmidt divider.
interface goldschmidt_div_if #(
    parameter int WIDTH = 28
) ();
    logic             start;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] x;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic             err;

    // Requester side: issues operands, observes status and result.
    modport master (
        output start, d, x,
        input  ready, busy, done, q, err
    );

    // Divider side.
    modport slave (
        input  start, d, x,
        output ready, busy, done, q, err
    );
endinterface

// File: rtl/gd_mul.sv
// Combinational Q1.(WIDTH-1) multiplier: full product, then drop the low
// WIDTH-1 fraction bits (truncation, no rounding). The top product bit is
// discarded; operand ranges keep the result below 2.0.
module gd_mul #(
    parameter int WIDTH = 28
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_p
);

    logic [2*WIDTH-1:0] w_full;

    assign w_full = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
    assign o_p    = WIDTH'(w_full >> (WIDTH - 1));

endmodule

// File: rtl/goldschmidt_div.sv
// Iterative Goldschmidt divider: q ~= x / d for a normalised divisor
// (d in [1.0, 2.0)). Each iteration scales N and D by K = 2 - D over two
// cycles on one shared multiplier, driving D towards 1.0 and N towards x/d.
module goldschmidt_div
    import goldschmidt_pkg::*;
#(
    parameter int WIDTH = 28,
    parameter int ITERS = 3
) (
    input  logic              clk,
    input  logic              reset,
    goldschmidt_div_if.slave  bus
);

    localparam logic [CNT_W-1:0] ITERS_C = CNT_W'(ITERS);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_n;
    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   r_q;
    logic               r_err;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   w_k;
    logic [WIDTH-1:0]   w_mul_a;
    logic [WIDTH-1:0]   w_prod;
    logic [CNT_W-1:0]   w_cnt_inc;

    logic               w_load;
    logic               w_reject;
    logic               w_upd_n;
    logic               w_upd_d;
    logic               w_finish;

    // K = 2 - D, i.e. the two's complement of D modulo 2.0. D only changes
    // in MUL_D, so the same K serves both halves of an iteration.
    assign w_k       = '0 - r_d;
    assign w_mul_a   = (r_state == MUL_D) ? r_d : r_n;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    gd_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .i_a (w_mul_a),
        .i_b (w_k),
        .o_p (w_prod)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and datapath strobes.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_reject    = 1'b0;
        w_upd_n     = 1'b0;
        w_upd_d     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    if (bus.d[WIDTH-1]) begin
                        w_load      = 1'b1;
                        w_state_nxt = MUL_N;
                    end else begin
                        w_reject    = 1'b1;
                        w_state_nxt = DONE;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            MUL_N: begin
                w_upd_n     = 1'b1;
                w_state_nxt = MUL_D;
            end
            MUL_D: begin
                w_upd_d = 1'b1;
                if (w_cnt_inc < ITERS_C) begin
                    w_state_nxt = MUL_N;
                end else begin
                    w_finish    = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand, counter and result registers.
    // NOTE: these are plain flops, not a memory array, so all of them are
    // cleared on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_n   <= '0;
            r_d   <= '0;
            r_q   <= '0;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            if (w_load) begin
                r_n   <= bus.x;
                r_d   <= bus.d;
                r_cnt <= '0;
                r_err <= 1'b0;
            end
            if (w_reject) begin
                r_q   <= '0;
                r_err <= 1'b1;
            end
            if (w_upd_n) begin
                r_n <= w_prod;
            end
            if (w_upd_d) begin
                r_d   <= w_prod;
                r_cnt <= w_cnt_inc;
            end
            if (w_finish) begin
                r_q <= r_n;
            end
        end
    end

    assign bus.ready = (r_state == IDLE) || (r_state == DONE);
    assign bus.busy  = (r_state == MUL_N) || (r_state == MUL_D);
    assign bus.done  = (r_state == DONE);
    assign bus.q     = r_q;
    assign bus.err   = r_err;

endmodule

// File: tb/tb_goldschmidt_div.sv
// Scoreboard bench for goldschmidt_div (WIDTH=28, ITERS=3): the driver pushes
// hand-computed results with their due cycle, a monitor pops and compares
// on every done pulse.
module tb_goldschmidt_div;

    localparam int W = 28;

    typedef struct {
        logic [W-1:0] q;
        logic         err;
        int           due;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;
    exp_t sb[$];

    goldschmidt_div_if #(.WIDTH(W)) bus ();

    goldschmidt_div #(
        .WIDTH (W),
        .ITERS (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare each done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(bus.done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("q", 32'(bus.q), 32'(e.q));
                check("err", 32'(bus.err), 32'(e.err));
                check("latency", cyc, e.due);
            end
        end
    end

    // Wait for ready, present one request, release start after the accept edge.
    task automatic issue(input logic [W-1:0] dv, input logic [W-1:0] xv,
                         input logic [W-1:0] eq, input logic ee);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(bus.ready), 32'd1);
        bus.start = 1'b1;
        bus.d     = dv;
        bus.x     = xv;
        sb.push_back('{q: eq, err: ee, due: cyc + (ee ? 1 : 7)});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
        sb.delete();
    endtask

    task automatic run_op(input logic [W-1:0] dv, input logic [W-1:0] xv,
                          input logic [W-1:0] eq, input logic ee);
        issue(dv, xv, eq, ee);
        drain();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.d     = '0;
        bus.x     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_q", 32'(bus.q), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        reset = 1'b0;

        // 1.75 / 1.5 -> 1.162109375 after three iterations
        run_op(28'hC000000, 28'hE000000, 28'h94C0000, 1'b0);
        // divide by exactly 1.0
        run_op(28'h8000000, 28'hE000000, 28'hE000000, 1'b0);
        // unnormalised divisor 0.5
        run_op(28'h4000000, 28'hE000000, 28'h0000000, 1'b1);
        // 1.0 / 1.25 -> 13107/16384, err cleared by a valid op
        run_op(28'hA000000, 28'h8000000, 28'h6666000, 1'b0);
        // zero dividend
        run_op(28'hC000000, 28'h0000000, 28'h0000000, 1'b0);
        // largest dividend over 1.0
        run_op(28'h8000000, 28'hFFFFFFF, 28'hFFFFFFF, 1'b0);
        // zero divisor and largest unnormalised divisor
        run_op(28'h0000000, 28'hE000000, 28'h0000000, 1'b1);
        run_op(28'h7FFFFFF, 28'h0000123, 28'h0000000, 1'b1);

        // start with new operands while busy is ignored
        issue(28'hC000000, 28'hE000000, 28'h94C0000, 1'b0);
        check("busy_mid", 32'(bus.busy), 32'd1);
        repeat (3) begin
            bus.start = 1'b1;
            bus.d     = 28'h8000000;
            bus.x     = 28'h4000000;
            @(negedge clk);
        end
        bus.start = 1'b0;
        drain();

        // back-to-back: start held high, second pair accepted in the done cycle
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!bus.ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            bus.start = 1'b1;
            bus.d     = 28'hC000000;
            bus.x     = 28'hE000000;
            sb.push_back('{q: 28'h94C0000, err: 1'b0, due: cyc + 7});
            @(negedge clk);
            bus.d = 28'hA000000;
            bus.x = 28'h8000000;
            n = 0;
            @(negedge clk);
            while (!bus.ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("b2b_done_cycle", 32'(bus.done), 32'd1);
            sb.push_back('{q: 28'h6666000, err: 1'b0, due: cyc + 7});
            @(negedge clk);
            bus.start = 1'b0;
            drain();
        end

        // reset 3 cycles into an operation aborts it with no done afterwards
        issue(28'hC000000, 28'hE000000, 28'h94C0000, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        sb.delete();
        check("abort_ready", 32'(bus.ready), 32'd1);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_q", 32'(bus.q), 32'd0);
        check("abort_err", 32'(bus.err), 32'd0);
        reset = 1'b0;
        repeat (12) @(negedge clk);

        // normal operation after the abort
        run_op(28'h8000000, 28'h4000000, 28'h4000000, 1'b0);

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/goldschmidt_div.md
GOLDSCHMIDT_DIV -- requirements
Module: goldschmidt_div

Interface
REQ-001 Parameter WIDTH, default 28, operand/result width; unsigned fixed point Q1.(WIDTH-1), bit WIDTH-1 is the integer bit.
REQ-002 Parameter ITERS, default 3, number of Goldschmidt iterations (1..8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a division; accepted only when ready=1.
REQ-006 d  input  WIDTH  divisor; sampled on the accepting edge.
REQ-007 x  input  WIDTH  dividend; sampled on the accepting edge.
REQ-008 ready  output  1  high in IDLE and DONE.
REQ-009 busy  output  1  high in MUL_N and MUL_D.
REQ-010 done  output  1  one-cycle pulse; q and err valid in that cycle.
REQ-011 q  output  WIDTH  quotient approximation x/d, Q1.(WIDTH-1); held until the next accepted start.
REQ-012 err  output  1  unnormalised divisor flag; held with q.

Function
REQ-013 States SHALL be IDLE, MUL_N, MUL_D, DONE.
REQ-014 IDLE/DONE with start=1 and d[WIDTH-1]=1: load N<=x, D<=d, iteration counter<=0, err<=0, go to MUL_N.
REQ-015 IDLE/DONE with start=1 and d[WIDTH-1]=0: q<=0, err<=1, go to DONE (done pulses next cycle); no iteration.
REQ-016 IDLE/DONE with start=0: DONE goes to IDLE; IDLE stays.
REQ-017 K SHALL be combinational 2-D, computed as the WIDTH-bit two's complement of D (modulo 2.0); D is not updated in MUL_N, so K is identical in both phases of an iteration.
REQ-018 MUL_N: N<=trunc(N*K); go to MUL_D.
REQ-019 MUL_D: D<=trunc(D*K); counter+1; go to MUL_N if counter+1<ITERS, else q<=trunc(N) and go to DONE.
REQ-020 A single shared WIDTH x WIDTH multiplier SHALL be used; operand A muxes N (MUL_N) or D (MUL_D); operand B is K.
REQ-021 trunc: take product bits [2*WIDTH-2 : WIDTH-1] (drop low WIDTH-1 fraction bits, no rounding); the range argument (N<2, K<2, D<=1 after iteration 1) guarantees no overflow.
REQ-022 Latency: accepting edge to done-high cycle = 2*ITERS+1 cycles for a valid divisor; 1 cycle for err.
REQ-023 start while busy=1 SHALL be ignored; d and x changes during busy SHALL NOT affect the result.
REQ-024 start in the done cycle SHALL be accepted (back-to-back operation, no IDLE bubble).

Reset
REQ-025 reset=1 at a clock edge SHALL force IDLE, ready=1, busy=0, done=0, q=0, err=0, N=D=0, counter=0.
REQ-026 reset SHALL take priority over start and abort any division in flight; no done pulse SHALL follow an aborted operation.

Structure
REQ-027 Package goldschmidt_pkg SHALL hold the state enum type and the ITERS-bounds constant.
REQ-028 One sub-module gd_mul (combinational truncating Q1 multiplier, WIDTH parameter) SHALL be instantiated once.

Verification
REQ-029 WIDTH=28, ITERS=3, d=0xC000000 (1.5), x=0xE000000 (1.75) -> done 7 cycles after the accepting edge, q=0x94C0000 (1.162109375), err=0.
REQ-030 d=0x8000000 (1.0), x=0xE000000 -> q=0xE000000 exactly, err=0.
REQ-031 d=0x4000000 (0.5, unnormalised), x=0xE000000 -> done on the next cycle, q=0, err=1.
REQ-032 Valid start, then start=1 with new d/x for 3 cycles mid-operation -> ignored; q matches the first operands.
REQ-033 reset asserted 3 cycles into an operation -> next cycle ready=1, busy=0, q=0; no done pulse afterwards.
REQ-034 start held high through the done cycle with a second operand pair -> second operation accepted in the done cycle, second done 7 cycles later.
